// File: rtl/uart_boot_loader_if.sv
// Bus bundle between the boot loader, the 16550-style UART controller
// register port and the memory write port.
interface uart_boot_loader_if;
    logic        uart_ren;
    logic        uart_wen;
    logic [2:0]  uart_address;
    logic [31:0] uart_word_in;
    logic [31:0] uart_data_out;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;

    modport master (
        output uart_ren, uart_wen, uart_address, uart_word_in,
        output mem_wen, mem_addr, mem_wdata, mem_wstrb,
        input  uart_data_out, mem_ready
    );

    modport slave (
        input  uart_ren, uart_wen, uart_address, uart_word_in,
        input  mem_wen, mem_addr, mem_wdata, mem_wstrb,
        output uart_data_out, mem_ready
    );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed image via the UART register port,
// writes it to memory as strobed words and returns an 8-bit checksum.
module uart_boot_loader #(
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter logic [31:0] MAX_LEN        = 32'h0001_0000,
    parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    uart_boot_loader_if.master bus,
    output logic busy,
    output logic done,
    output logic error
);

    typedef enum logic [3:0] {
        IDLE, INIT_LCR, POLL_REQ, POLL_CHK, RD_REQ, RD_CHK,
        WAIT_CLR_REQ, WAIT_CLR_CHK, PARSE, MEM_WR,
        TX_POLL_REQ, TX_POLL_CHK, TX_WR, DONE, ERR
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  A_DATA   = 3'd0;
    localparam logic [2:0]  A_LCR    = 3'd3;
    localparam logic [2:0]  A_LSR    = 3'd5;

    state_t      state;
    logic [7:0]  rx_byte;
    logic [7:0]  csum;
    logic [3:0]  hdr_cnt;
    logic [31:0] len;
    logic [31:0] load_addr;
    logic [31:0] pay_cnt;
    logic [31:0] idle_cnt;
    logic [31:0] wbuf;
    logic [3:0]  strb;

    logic [31:0] wbuf_n;
    logic [3:0]  strb_n;
    logic [31:0] pay_next;
    logic [31:0] addr_full;
    logic [7:0]  rd_data;
    logic        timed_out;

    always_comb begin
        wbuf_n = wbuf;
        strb_n = strb;
        wbuf_n[{pay_cnt[1:0], 3'b000} +: 8] = rx_byte;
        strb_n[pay_cnt[1:0]] = 1'b1;
        pay_next  = pay_cnt + 32'd1;
        addr_full = {rx_byte, load_addr[31:8]};
        rd_data   = bus.uart_data_out[7:0];
        // Idle timer only arms once the magic byte has been accepted.
        timed_out = (hdr_cnt != 4'd0) && (idle_cnt == TMO_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            rx_byte          <= '0;
            csum             <= '0;
            hdr_cnt          <= '0;
            len              <= '0;
            load_addr        <= '0;
            pay_cnt          <= '0;
            idle_cnt         <= '0;
            wbuf             <= '0;
            strb             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            bus.uart_ren     <= 1'b0;
            bus.uart_wen     <= 1'b0;
            bus.uart_address <= '0;
            bus.uart_word_in <= '0;
            bus.mem_wen      <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.mem_wstrb    <= '0;
        end else begin
            bus.uart_ren <= 1'b0;
            bus.uart_wen <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        done             <= 1'b0;
                        error            <= 1'b0;
                        csum             <= '0;
                        hdr_cnt          <= '0;
                        pay_cnt          <= '0;
                        idle_cnt         <= '0;
                        wbuf             <= '0;
                        strb             <= '0;
                        busy             <= 1'b1;
                        bus.uart_wen     <= 1'b1;
                        bus.uart_address <= A_LCR;
                        bus.uart_word_in <= {4{8'h03}};
                        state            <= INIT_LCR;
                    end
                end
                INIT_LCR: begin
                    bus.uart_ren     <= 1'b1;
                    bus.uart_address <= A_LSR;
                    state            <= POLL_REQ;
                end
                POLL_REQ: begin
                    if (timed_out) begin
                        state <= ERR;
                    end else begin
                        if (hdr_cnt != 4'd0) idle_cnt <= idle_cnt + 32'd1;
                        state <= POLL_CHK;
                    end
                end
                POLL_CHK: begin
                    if (timed_out) begin
                        state <= ERR;
                    end else begin
                        if (hdr_cnt != 4'd0) idle_cnt <= idle_cnt + 32'd1;
                        bus.uart_ren <= 1'b1;
                        if (rd_data[0]) begin
                            bus.uart_address <= A_DATA;
                            state            <= RD_REQ;
                        end else begin
                            bus.uart_address <= A_LSR;
                            state            <= POLL_REQ;
                        end
                    end
                end
                RD_REQ: state <= RD_CHK;
                RD_CHK: begin
                    rx_byte          <= rd_data;
                    bus.uart_ren     <= 1'b1;
                    bus.uart_address <= A_LSR;
                    state            <= WAIT_CLR_REQ;
                end
                WAIT_CLR_REQ: state <= WAIT_CLR_CHK;
                WAIT_CLR_CHK: begin
                    if (rd_data[0]) begin
                        bus.uart_ren     <= 1'b1;
                        bus.uart_address <= A_LSR;
                        state            <= WAIT_CLR_REQ;
                    end else begin
                        state <= PARSE;
                    end
                end
                PARSE: begin
                    idle_cnt <= '0;
                    if (hdr_cnt == 4'd0) begin
                        if (rx_byte != MAGIC) begin
                            state <= ERR;
                        end else begin
                            hdr_cnt          <= 4'd1;
                            bus.uart_ren     <= 1'b1;
                            bus.uart_address <= A_LSR;
                            state            <= POLL_REQ;
                        end
                    end else if (hdr_cnt < 4'd5) begin
                        len              <= {rx_byte, len[31:8]};
                        hdr_cnt          <= hdr_cnt + 4'd1;
                        bus.uart_ren     <= 1'b1;
                        bus.uart_address <= A_LSR;
                        state            <= POLL_REQ;
                    end else if (hdr_cnt < 4'd8) begin
                        load_addr        <= addr_full;
                        hdr_cnt          <= hdr_cnt + 4'd1;
                        bus.uart_ren     <= 1'b1;
                        bus.uart_address <= A_LSR;
                        state            <= POLL_REQ;
                    end else if (hdr_cnt == 4'd8) begin
                        load_addr <= addr_full;
                        hdr_cnt   <= 4'd9;
                        if (len > MAX_LEN || addr_full[1:0] != 2'b00) begin
                            state <= ERR;
                        end else begin
                            bus.uart_ren     <= 1'b1;
                            bus.uart_address <= A_LSR;
                            state <= (len == 32'd0) ? TX_POLL_REQ : POLL_REQ;
                        end
                    end else begin
                        wbuf    <= wbuf_n;
                        strb    <= strb_n;
                        csum    <= csum + rx_byte;
                        pay_cnt <= pay_next;
                        if (pay_cnt[1:0] == 2'd3 || pay_next == len) begin
                            bus.mem_wen   <= 1'b1;
                            bus.mem_addr  <= load_addr + {pay_cnt[31:2], 2'b00};
                            bus.mem_wdata <= wbuf_n;
                            bus.mem_wstrb <= strb_n;
                            state         <= MEM_WR;
                        end else begin
                            bus.uart_ren     <= 1'b1;
                            bus.uart_address <= A_LSR;
                            state            <= POLL_REQ;
                        end
                    end
                end
                MEM_WR: begin
                    if (bus.mem_ready) begin
                        bus.mem_wen      <= 1'b0;
                        wbuf             <= '0;
                        strb             <= '0;
                        bus.uart_ren     <= 1'b1;
                        bus.uart_address <= A_LSR;
                        state <= (pay_cnt == len) ? TX_POLL_REQ : POLL_REQ;
                    end
                end
                TX_POLL_REQ: state <= TX_POLL_CHK;
                TX_POLL_CHK: begin
                    if (rd_data[5]) begin
                        bus.uart_wen     <= 1'b1;
                        bus.uart_address <= A_DATA;
                        bus.uart_word_in <= {4{csum}};
                        state            <= TX_WR;
                    end else begin
                        bus.uart_ren     <= 1'b1;
                        bus.uart_address <= A_LSR;
                        state            <= TX_POLL_REQ;
                    end
                end
                TX_WR: state <= DONE;
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: UART/memory responder, frame-level
// reference model and a per-cycle compare process.
module tb_uart_boot_loader;
    localparam int TMO = 300;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done, error;

    uart_boot_loader_if bus();

    uart_boot_loader #(
        .MAGIC(8'hA5),
        .MAX_LEN(32'h0001_0000),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    // Reference expectations for the frame in flight.
    wr_t        expw[$];
    logic [7:0] exp_tx;
    bit         exp_tx_v, exp_done, exp_err;

    task automatic model(input byte unsigned f[$]);
        logic [31:0] len, a;
        int p;
        logic [7:0] cs;
        expw.delete();
        exp_tx_v = 0; exp_done = 0; exp_err = 0; exp_tx = 0;
        if (f.size() < 1 || f[0] != 8'hA5 || f.size() < 9) begin
            exp_err = 1;
            return;
        end
        len = {f[4], f[3], f[2], f[1]};
        a   = {f[8], f[7], f[6], f[5]};
        if (len > 32'h0001_0000 || a[1:0] != 2'b00) begin
            exp_err = 1;
            return;
        end
        p = f.size() - 9;
        if (p > int'(len)) p = int'(len);
        cs = 0;
        for (int k = 0; k < p; k++) cs += f[9 + k];
        for (int w = 0; w * 4 < p; w++) begin
            wr_t e;
            if (w * 4 + 4 > p && p < int'(len)) break;
            e.a = a + 32'(4 * w);
            e.d = 0;
            e.s = 0;
            for (int j = 0; j < 4 && w * 4 + j < p; j++) begin
                e.d[8 * j +: 8] = f[9 + w * 4 + j];
                e.s[j] = 1'b1;
            end
            expw.push_back(e);
        end
        if (p < int'(len)) begin
            exp_err = 1;
        end else begin
            exp_done = 1;
            exp_tx_v = 1;
            exp_tx   = cs;
        end
    endtask

    // UART controller and memory responder.
    byte unsigned rxq[$];
    logic [7:0] rbr = 0;
    bit dr = 0, seen_empty = 1, rx_stall = 0, drv;
    int lag = 0, lag_cfg = 0, thre_cnt = 0, stall_len = 0, wcnt = 0;
    int rbr_reads = 0, bad_reads = 0, tx_cnt = 0;

    initial begin
        bus.uart_data_out = 0;
        bus.mem_ready = 0;
    end

    always @(posedge clk) begin
        #1;
        if (bus.mem_wen) begin
            if (wcnt < stall_len) begin
                bus.mem_ready = 0;
                wcnt++;
            end else begin
                bus.mem_ready = 1;
            end
        end else begin
            wcnt = 0;
            bus.mem_ready = (stall_len == 0);
        end
        if (bus.uart_ren) begin
            if (bus.uart_address == 3'd5) begin
                drv = dr || lag > 0;
                bus.uart_data_out = {26'd0, thre_cnt == 0, 4'd0, drv};
                if (thre_cnt > 0) thre_cnt--;
                if (!dr && lag > 0) lag--;
                if (!drv) seen_empty = 1;
            end else if (bus.uart_address == 3'd0) begin
                if (!dr) bad_reads++;
                bus.uart_data_out = {4{rbr}};
                dr = 0;
                lag = lag_cfg;
                rbr_reads++;
            end
        end
        if (!dr && lag == 0 && seen_empty && !rx_stall && rxq.size() > 0) begin
            rbr = rxq.pop_front();
            dr = 1;
            seen_empty = 0;
        end
    end

    // Compare process.
    bit chk_en = 0;
    bit p_wen = 0, p_acc = 0, acc;
    logic [31:0] p_a, p_d;
    logic [3:0] p_s;
    wr_t ew;

    always @(negedge clk) begin
        if (chk_en && reset) begin
            chk("strobe_excl", 32'(bus.uart_ren & bus.uart_wen), 0);
            chk("ren_in_mem_wr", 32'(bus.mem_wen & bus.uart_ren), 0);
            if (bus.uart_wen && bus.uart_address == 3'd3)
                chk("lcr_value", bus.uart_word_in, 32'h0303_0303);
            if (bus.uart_wen && bus.uart_address == 3'd0) begin
                tx_cnt++;
                chk("tx_allowed", 32'(exp_tx_v), 1);
                chk("tx_byte", bus.uart_word_in, {4{exp_tx}});
            end
            if (p_wen && !p_acc) begin
                chk("mem_hold_wen", 32'(bus.mem_wen), 1);
                chk("mem_hold_addr", bus.mem_addr, p_a);
                chk("mem_hold_data", bus.mem_wdata, p_d);
                chk("mem_hold_strb", 32'(bus.mem_wstrb), 32'(p_s));
            end
            if (p_acc) chk("mem_wen_drop", 32'(bus.mem_wen), 0);
            acc = bus.mem_wen && bus.mem_ready;
            if (acc) begin
                chk("mem_expected", 32'(expw.size() > 0), 1);
                if (expw.size() > 0) begin
                    ew = expw.pop_front();
                    chk("mem_addr", bus.mem_addr, ew.a);
                    chk("mem_data", bus.mem_wdata, ew.d);
                    chk("mem_strb", 32'(bus.mem_wstrb), 32'(ew.s));
                end
            end
            p_wen = bus.mem_wen;
            p_acc = acc;
            p_a = bus.mem_addr;
            p_d = bus.mem_wdata;
            p_s = bus.mem_wstrb;
        end else begin
            p_wen = 0;
            p_acc = 0;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, ":ctl"}, 32'({busy, done, error, bus.uart_ren, bus.uart_wen,
                               bus.mem_wen, bus.uart_address, bus.mem_wstrb}), 0);
        chk({tag, ":word_in"}, bus.uart_word_in, 0);
        chk({tag, ":mem_addr"}, bus.mem_addr, 0);
        chk({tag, ":mem_wdata"}, bus.mem_wdata, 0);
    endtask

    task automatic prep(input byte unsigned f[$], input int lag_c,
                        input int thre_c, input int stl);
        model(f);
        rxq = f;
        dr = 0; lag = 0; seen_empty = 1;
        lag_cfg = lag_c; thre_cnt = thre_c; stall_len = stl;
        tx_cnt = 0; rbr_reads = 0; bad_reads = 0;
    endtask

    task automatic run(input string name, input byte unsigned f[$],
                       input int lag_c, input int thre_c, input int stl,
                       input int pre_stall, input bit extra_start);
        int n;
        prep(f, lag_c, thre_c, stl);
        rx_stall = pre_stall > 0;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        chk({name, ":busy_rise"}, 32'(busy), 1);
        if (pre_stall > 0) begin
            repeat (pre_stall) @(negedge clk);
            rx_stall = 0;
        end
        if (extra_start) begin
            repeat (30) @(negedge clk);
            start = 1;
            @(negedge clk) start = 0;
        end
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({name, ":finished"}, 32'(busy), 0);
        chk({name, ":done"}, 32'(done), 32'(exp_done));
        chk({name, ":error"}, 32'(error), 32'(exp_err));
        chk({name, ":tx_count"}, 32'(tx_cnt), 32'(exp_tx_v));
        chk({name, ":writes_left"}, 32'(expw.size()), 0);
        chk({name, ":bytes_read"}, 32'(rbr_reads), 32'(f.size()));
        chk({name, ":empty_reads"}, 32'(bad_reads), 0);
        rxq.delete();
        repeat (3) @(negedge clk);
    endtask

    byte unsigned fa[$], fb[$], fc[$], fd[$], fe[$], ff[$], fg[$], fh[$];

    initial begin
        int n;
        fa = '{8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        fb = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        fc = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00};
        fd = '{8'h5A};
        fe = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h02, 8'h10, 8'h00, 8'h00};
        ff = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
        fg = '{8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
               8'h11, 8'h22, 8'h33};
        fh = '{8'hA5, 8'h06, 8'h00, 8'h00, 8'h00, 8'hFC, 8'hFF, 8'hFF, 8'hFF,
               8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};

        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1;
        @(negedge clk);
        chk_en = 1;

        model(fa);
        chk("pin_a_w0_addr", expw[0].a, 32'h0000_1000);
        chk("pin_a_w0_data", expw[0].d, 32'h0403_0201);
        chk("pin_a_w1_data", expw[1].d, 32'h0807_0605);
        chk("pin_a_csum", 32'(exp_tx), 32'h24);
        model(fb);
        chk("pin_b_w1_data", expw[1].d, 32'h0000_00FF);
        chk("pin_b_w1_strb", 32'(expw[1].s), 32'h1);
        chk("pin_b_csum", 32'(exp_tx), 32'hFB);
        model(fh);
        chk("pin_h_w1_addr", expw[1].a, 32'h0000_0000);
        chk("pin_h_w1_strb", 32'(expw[1].s), 32'h3);

        run("frame8", fa, 0, 0, 0, 0, 1);
        run("ff_x5_dr_lag", fb, 2, 3, 0, 0, 0);
        run("len0_late_magic", fc, 0, 2, 0, TMO + 100, 0);
        run("bad_magic", fd, 0, 0, 0, 0, 0);
        run("bad_addr", fe, 0, 0, 0, 0, 0);
        run("bad_len", ff, 0, 0, 0, 0, 0);
        run("rx_timeout", fg, 0, 0, 0, 0, 0);
        run("mem_stall_wrap", fh, 1, 0, 10, 0, 0);

        prep(fa, 0, 0, 0);
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        n = 0;
        while (rbr_reads < 11 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reset:reached_payload", 32'(rbr_reads >= 11), 1);
        chk_en = 0;
        reset = 0;
        #1;
        check_zero("mid_reset:async");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("mid_reset:quiet", 32'({bus.uart_ren, bus.uart_wen,
                                        bus.mem_wen, busy}), 0);
        end
        reset = 1;
        rxq.delete();
        expw.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_reset:idle", 32'({bus.uart_ren, bus.uart_wen,
                                        bus.mem_wen, busy, done, error}), 0);
        end
        chk_en = 1;
        run("after_reset", fb, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
